// File: rtl/rv32_multicycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32_multicycle_core
//  Description : Multi-cycle RV32I/RV32E core with separate req/ack
//                instruction and data buses, precise traps and a retire
//                strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
    parameter int          NREGS    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_data,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [1:0]  o_dbus_size,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic [31:0] o_pc,
    output logic        o_retire,
    output logic        o_trap,
    output logic [3:0]  o_cause
);

    localparam int         RIDX    = (NREGS == 16) ? 4 : 5;
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] CAUSE_FETCH_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK         = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL          = 4'd11;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        TRAP  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ibus_req;
    logic        dbus_req;
    logic        dbus_we;
    logic [1:0]  dbus_size;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        retire;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] wb_val;
    logic [31:0] next_pc_q;
    logic        wb_en;

    logic [31:0] rf [NREGS];

    // ---------------- decode fields ----------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    // Asynchronous register-file read; x0 and out-of-range indices read as 0
    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREGS_L) rs1_val = rf[rs1[RIDX-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < NREGS_L) rs2_val = rf[rs2[RIDX-1:0]];
    end

    // ---------------- legality / format classification ----------------
    logic illegal;
    logic is_ecall;
    logic is_ebreak;
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;

    // Classify the instruction and flag unknown encodings or missing registers
    always_comb begin
        illegal   = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        uses_rd   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: uses_rd = 1'b1;
            OP_JALR: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                illegal  = (funct3 != 3'd0);
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct3 > 3'd2);
            end
            OP_OPIMM: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                if (funct3 == 3'd1)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'd5)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OP_OP: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = !((funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
            end
            OP_FENCE: illegal = (funct3 != 3'd0);
            OP_SYSTEM: begin
                if (ir == 32'h0000_0073)      is_ecall  = 1'b1;
                else if (ir == 32'h0010_0073) is_ebreak = 1'b1;
                else                          illegal   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (uses_rs1 && {1'b0, rs1} >= NREGS_L) illegal = 1'b1;
        if (uses_rs2 && {1'b0, rs2} >= NREGS_L) illegal = 1'b1;
        if (uses_rd  && {1'b0, rd}  >= NREGS_L) illegal = 1'b1;
    end

    // ---------------- ALU ----------------
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_sra;
    logic [31:0] alu_y;

    assign alu_b   = (opcode == OP_OP) ? rs2_val : imm_i;
    assign shamt   = alu_b[4:0];
    assign alu_sra = $signed(rs1_val) >>> shamt;

    // Integer ALU shared by OP and OP-IMM
    always_comb begin
        alu_y = 32'd0;
        case (funct3)
            3'd0: alu_y = (opcode == OP_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1: alu_y = rs1_val << shamt;
            3'd2: alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rs1_val < alu_b};
            3'd4: alu_y = rs1_val ^ alu_b;
            3'd5: alu_y = funct7[5] ? alu_sra : (rs1_val >> shamt);
            3'd6: alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    // ---------------- control flow, memory address, result ----------------
    logic        br_cond;
    logic        taken;
    logic [31:0] target;
    logic [31:0] jalr_sum;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        is_load;
    logic        is_store;
    logic [31:0] mem_addr;
    logic        mem_misaligned;
    logic [31:0] exec_result;

    assign pc_plus4 = pc + 32'd4;
    assign jalr_sum = rs1_val + imm_i;
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
    assign mem_misaligned = (funct3[1:0] == 2'd1 && mem_addr[0]) ||
                            (funct3[1:0] == 2'd2 && mem_addr[1:0] != 2'd0);

    // Branch condition, jump target and the value destined for rd
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'd0: br_cond = (rs1_val == rs2_val);
            3'd1: br_cond = (rs1_val != rs2_val);
            3'd4: br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: br_cond = (rs1_val <  rs2_val);
            3'd7: br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
        taken  = 1'b0;
        target = pc + imm_b;
        case (opcode)
            OP_JAL: begin
                taken  = 1'b1;
                target = pc + imm_j;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = {jalr_sum[31:1], 1'b0};
            end
            OP_BRANCH: taken = br_cond;
            default: taken = 1'b0;
        endcase
        next_pc = taken ? target : pc_plus4;
        case (opcode)
            OP_LUI:          exec_result = imm_u;
            OP_AUIPC:        exec_result = pc + imm_u;
            OP_JAL, OP_JALR: exec_result = pc_plus4;
            default:         exec_result = alu_y;
        endcase
    end

    logic       exc;
    logic [3:0] exc_cause;

    // Trap selection in priority order
    always_comb begin
        exc       = 1'b1;
        exc_cause = CAUSE_ILLEGAL;
        if (illegal)                                exc_cause = CAUSE_ILLEGAL;
        else if (is_ecall)                          exc_cause = CAUSE_ECALL;
        else if (is_ebreak)                         exc_cause = CAUSE_EBREAK;
        else if (is_load && mem_misaligned)         exc_cause = CAUSE_LOAD_MISALIGN;
        else if (is_store && mem_misaligned)        exc_cause = CAUSE_STORE_MISALIGN;
        else if (taken && target[1])                exc_cause = CAUSE_FETCH_MISALIGN;
        else                                        exc       = 1'b0;
    end

    logic [31:0] load_ext;

    // Sign/zero extension of right-justified load data
    always_comb begin
        case (funct3)
            3'd0:    load_ext = {{24{i_dbus_rdata[7]}}, i_dbus_rdata[7:0]};
            3'd1:    load_ext = {{16{i_dbus_rdata[15]}}, i_dbus_rdata[15:0]};
            3'd4:    load_ext = {24'd0, i_dbus_rdata[7:0]};
            3'd5:    load_ext = {16'd0, i_dbus_rdata[15:0]};
            default: load_ext = i_dbus_rdata;
        endcase
    end

    // Main control FSM; all bus and status outputs are registered here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            ibus_req  <= 1'b0;
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            dbus_size <= 2'd0;
            dbus_addr <= 32'd0;
            dbus_wdata <= 32'd0;
            retire    <= 1'b0;
            trap      <= 1'b0;
            cause     <= 4'd0;
            wb_val    <= 32'd0;
            next_pc_q <= RESET_PC;
            wb_en     <= 1'b0;
        end else begin
            retire <= 1'b0;
            trap   <= 1'b0;
            case (state)
                FETCH: begin
                    if (ibus_req && i_ibus_ack) begin
                        ir       <= i_ibus_data;
                        ibus_req <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        ibus_req <= 1'b1;
                    end
                end
                EXEC: begin
                    next_pc_q <= next_pc;
                    wb_en     <= uses_rd && (rd != 5'd0);
                    wb_val    <= exec_result;
                    if (exc) begin
                        trap  <= 1'b1;
                        cause <= exc_cause;
                        state <= TRAP;
                    end else if (is_load || is_store) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_size  <= funct3[1:0] + 2'd1;
                        dbus_addr  <= mem_addr;
                        dbus_wdata <= rs2_val;
                        state      <= MEM;
                    end else begin
                        retire <= 1'b1;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (i_dbus_ack) begin
                        dbus_req  <= 1'b0;
                        dbus_we   <= 1'b0;
                        dbus_size <= 2'd0;
                        if (!dbus_we) wb_val <= load_ext;
                        retire    <= 1'b1;
                        state     <= WB;
                    end
                end
                WB: begin
                    pc       <= next_pc_q;
                    ibus_req <= 1'b1;
                    state    <= FETCH;
                end
                TRAP: begin
                    pc       <= TRAP_PC;
                    ibus_req <= 1'b1;
                    state    <= FETCH;
                end
                default: begin
                    ibus_req <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

    // Register-file write port, active only in the write-back cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == WB && wb_en) begin
            rf[rd[RIDX-1:0]] <= wb_val;
        end
    end

    assign o_ibus_req   = ibus_req;
    assign o_ibus_addr  = pc;
    assign o_dbus_req   = dbus_req;
    assign o_dbus_we    = dbus_we;
    assign o_dbus_size  = dbus_size;
    assign o_dbus_addr  = dbus_addr;
    assign o_dbus_wdata = dbus_wdata;
    assign o_pc         = pc;
    assign o_retire     = retire;
    assign o_trap       = trap;
    assign o_cause      = cause;

endmodule
`default_nettype wire

// File: tb/tb_rv32_multicycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_multicycle_core
//  Description : Directed self-checking bench for rv32_multicycle_core
//                (RV32I instance with wait-state memories, RV32E instance
//                with zero-wait memories).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_multicycle_core;

    localparam logic [31:0] JLOOP = 32'h0000_006F;   // jal x0,0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic rst_e = 1'b1;

    // RV32I instance signals
    logic        ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack, retire, trap;
    logic [31:0] ibus_addr, ibus_data, dbus_addr, dbus_wdata, dbus_rdata, pc;
    logic [1:0]  dbus_size;
    logic [3:0]  cause;

    // RV32E instance signals
    logic        e_ibus_req, e_ibus_ack, e_dbus_req, e_dbus_we, e_dbus_ack, e_retire, e_trap;
    logic [31:0] e_ibus_addr, e_ibus_data, e_dbus_addr, e_dbus_wdata, e_dbus_rdata, e_pc;
    logic [1:0]  e_dbus_size;
    logic [3:0]  e_cause;

    rv32_multicycle_core #(.RESET_PC(32'h0), .TRAP_PC(32'h100), .NREGS(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_ibus_req(ibus_req), .o_ibus_addr(ibus_addr), .i_ibus_ack(ibus_ack), .i_ibus_data(ibus_data),
        .o_dbus_req(dbus_req), .o_dbus_we(dbus_we), .o_dbus_size(dbus_size), .o_dbus_addr(dbus_addr),
        .o_dbus_wdata(dbus_wdata), .i_dbus_ack(dbus_ack), .i_dbus_rdata(dbus_rdata),
        .o_pc(pc), .o_retire(retire), .o_trap(trap), .o_cause(cause)
    );

    rv32_multicycle_core #(.RESET_PC(32'h0), .TRAP_PC(32'h100), .NREGS(16)) dut_e (
        .i_clk(clk), .i_rst(rst_e),
        .o_ibus_req(e_ibus_req), .o_ibus_addr(e_ibus_addr), .i_ibus_ack(e_ibus_ack), .i_ibus_data(e_ibus_data),
        .o_dbus_req(e_dbus_req), .o_dbus_we(e_dbus_we), .o_dbus_size(e_dbus_size), .o_dbus_addr(e_dbus_addr),
        .o_dbus_wdata(e_dbus_wdata), .i_dbus_ack(e_dbus_ack), .i_dbus_rdata(e_dbus_rdata),
        .o_pc(e_pc), .o_retire(e_retire), .o_trap(e_trap), .o_cause(e_cause)
    );

    // Memories with programmable wait states for the RV32I instance
    logic [31:0] imem   [256];
    logic [31:0] dmem   [256];
    logic [31:0] imem_e [256];
    int  iwait = 0;
    int  dwait = 0;
    int  icnt  = 0;
    int  dcnt  = 0;
    bit  dack_force = 1'b0;
    logic [31:0] dword;

    assign ibus_ack   = ibus_req && (icnt >= iwait);
    assign ibus_data  = imem[ibus_addr[9:2]];
    assign dbus_ack   = (dbus_req && (dcnt >= dwait)) || dack_force;
    assign dword      = dmem[dbus_addr[9:2]] >> {dbus_addr[1:0], 3'b000};
    assign dbus_rdata = (dbus_size == 2'd1) ? {24'd0, dword[7:0]} :
                        (dbus_size == 2'd2) ? {16'd0, dword[15:0]} : dword;

    always @(posedge clk) begin
        icnt <= (!ibus_req || ibus_ack) ? 0 : icnt + 1;
        dcnt <= (!dbus_req || dbus_ack) ? 0 : dcnt + 1;
    end

    always @(posedge clk) begin
        if (dbus_req && dbus_ack && dbus_we) begin
            case (dbus_size)
                2'd1:    dmem[dbus_addr[9:2]][{dbus_addr[1:0], 3'b000} +: 8] = dbus_wdata[7:0];
                2'd2:    dmem[dbus_addr[9:2]][{dbus_addr[1], 4'b0000} +: 16] = dbus_wdata[15:0];
                default: dmem[dbus_addr[9:2]] = dbus_wdata;
            endcase
        end
    end

    // Zero-wait memories for the RV32E instance
    assign e_ibus_ack   = e_ibus_req;
    assign e_ibus_data  = imem_e[e_ibus_addr[9:2]];
    assign e_dbus_ack   = e_dbus_req;
    assign e_dbus_rdata = 32'd0;

    int e_ret_cnt  = 0;
    int e_dreq_cnt = 0;
    int cyc        = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_e) begin
            if (e_retire)   e_ret_cnt  <= e_ret_cnt + 1;
            if (e_dbus_req) e_dreq_cnt <= e_dreq_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // which: 0 retire, 1 ibus_req, 2 dbus_req, 3 trap, 4 RV32E trap
    task automatic wait_for(input string tag, input int which, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       hit = retire;
                1:       hit = ibus_req;
                2:       hit = dbus_req;
                3:       hit = trap;
                default: hit = e_trap;
            endcase
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    int c1, c2, nret, cret;
    bit ih, dh, dseen, unstable;
    logic [31:0] ia, da, dw, cap_addr, cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_we;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i]   = JLOOP;
            dmem[i]   = 32'd0;
            imem_e[i] = JLOOP;
        end
        imem_e[0]  = 32'h00100A13;   // addi x20,x0,1 (illegal on RV32E)
        imem_e[64] = 32'h00202083;   // lw x1,2(x0) at TRAP_PC (misaligned)

        // ---- Test 1: reset state, ALU instructions, 3-cycle retire ----
        imem[0] = 32'h00500093;      // addi x1,x0,5
        imem[1] = 32'hFF908113;      // addi x2,x1,-7
        repeat (2) @(posedge clk);
        #1;
        check("rst_ibus_req",  {31'd0, ibus_req}, 32'd0);
        check("rst_dbus_req",  {31'd0, dbus_req}, 32'd0);
        check("rst_dbus_size", {30'd0, dbus_size}, 32'd0);
        check("rst_dbus_we",   {31'd0, dbus_we}, 32'd0);
        check("rst_retire",    {31'd0, retire}, 32'd0);
        check("rst_trap",      {31'd0, trap}, 32'd0);
        check("rst_cause",     {28'd0, cause}, 32'd0);
        check("rst_pc",        pc, 32'h0);
        rst = 1'b0;
        wait_for("t1_first_fetch", 1, 10);
        check("t1_fetch_addr", ibus_addr, 32'h0);
        wait_for("t1_retire1", 0, 20);
        c1 = cyc;
        wait_for("t1_retire2", 0, 20);
        c2 = cyc;
        check("t1_retire_spacing", 32'(c2 - c1), 32'd3);
        @(posedge clk);
        #1;
        check("t1_x1", dut.rf[1], 32'd5);
        check("t1_x2", dut.rf[2], 32'hFFFF_FFFE);

        // ---- Test 2: LB / LBU extension ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        imem[0]  = 32'h04000183;     // lb  x3,0x40(x0)
        imem[1]  = 32'h04004203;     // lbu x4,0x40(x0)
        imem[2]  = JLOOP;
        dmem[16] = 32'h0000_80F0;
        rst = 1'b0;
        wait_for("t2_dbus_req", 2, 20);
        check("t2_size", {30'd0, dbus_size}, 32'd1);
        check("t2_we",   {31'd0, dbus_we}, 32'd0);
        check("t2_addr", dbus_addr, 32'h40);
        wait_for("t2_retire1", 0, 20);
        c1 = cyc;
        wait_for("t2_retire2", 0, 20);
        c2 = cyc;
        check("t2_load_spacing", 32'(c2 - c1), 32'd4);
        @(posedge clk);
        #1;
        check("t2_x3", dut.rf[3], 32'hFFFF_FFF0);
        check("t2_x4", dut.rf[4], 32'h0000_00F0);

        // ---- Test 3: SW with fetch and data wait states ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        iwait   = 3;
        dwait   = 2;
        imem[0] = 32'h12300293;      // addi x5,x0,0x123
        imem[1] = 32'h04502223;      // sw x5,0x44(x0)
        imem[2] = JLOOP;
        rst = 1'b0;
        wait_for("t3_retire_addi", 0, 30);
        nret = 0; cret = 0; ih = 0; dh = 0; dseen = 0; unstable = 0;
        ia = 0; da = 0; dw = 0; cap_addr = 0; cap_wdata = 0; cap_size = 0; cap_we = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (retire) begin
                nret++;
                cret = i;
            end
            if (ibus_req) begin
                if (ih && ibus_addr !== ia) unstable = 1'b1;
                ia = ibus_addr;
                ih = !ibus_ack;
            end else if (ih) begin
                unstable = 1'b1;
            end
            if (dbus_req) begin
                if (!dseen) begin
                    cap_addr  = dbus_addr;
                    cap_wdata = dbus_wdata;
                    cap_size  = dbus_size;
                    cap_we    = dbus_we;
                end
                dseen = 1'b1;
                if (dh && (dbus_addr !== da || dbus_wdata !== dw)) unstable = 1'b1;
                da = dbus_addr;
                dw = dbus_wdata;
                dh = !dbus_ack;
            end else if (dh) begin
                unstable = 1'b1;
            end
        end
        check("t3_retire_count",  32'(nret), 32'd1);
        check("t3_retire_cycle",  32'(cret), 32'd9);
        check("t3_bus_stable",    {31'd0, unstable}, 32'd0);
        check("t3_store_size",    {30'd0, cap_size}, 32'd3);
        check("t3_store_we",      {31'd0, cap_we}, 32'd1);
        check("t3_store_addr",    cap_addr, 32'h44);
        check("t3_store_wdata",   cap_wdata, 32'h123);
        check("t3_mem_word",      dmem[17], 32'h123);

        // ---- Test 4: backward branch, misaligned JALR target trap ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        iwait   = 0;
        dwait   = 0;
        imem[0] = 32'h0200006F;      // jal x0,0x20
        imem[1] = JLOOP;
        imem[6] = 32'h003000E7;      // 0x18: jalr x1,3(x0)
        imem[8] = 32'hFE000CE3;      // 0x20: beq x0,x0,-8
        rst = 1'b0;
        wait_for("t4_retire_jal", 0, 20);
        wait_for("t4_retire_beq", 0, 20);
        wait_for("t4_fetch_after_beq", 1, 10);
        check("t4_branch_target", ibus_addr, 32'h18);
        wait_for("t4_trap", 3, 20);
        check("t4_cause",        {28'd0, cause}, 32'd0);
        check("t4_no_retire",    {31'd0, retire}, 32'd0);
        check("t4_trap_pc",      pc, 32'h18);
        @(posedge clk);
        #1;
        check("t4_trap_one_cycle", {31'd0, trap}, 32'd0);
        check("t4_refetch_req",  {31'd0, ibus_req}, 32'd1);
        check("t4_refetch_addr", ibus_addr, 32'h100);
        check("t4_x1_kept",      dut.rf[1], 32'd5);

        // ---- Test 5: RV32E illegal register and misaligned load ----
        rst_e = 1'b0;
        wait_for("t5_trap_illegal", 4, 20);
        check("t5_cause_illegal", {28'd0, e_cause}, 32'd2);
        check("t5_pc_illegal",    e_pc, 32'h0);
        wait_for("t5_trap_lw", 4, 20);
        check("t5_cause_lw",      {28'd0, e_cause}, 32'd4);
        check("t5_pc_lw",         e_pc, 32'h100);
        check("t5_no_retire",     32'(e_ret_cnt), 32'd0);
        check("t5_no_dbus_req",   32'(e_dreq_cnt), 32'd0);

        // ---- Test 6: reset while MEM waits; late ack ignored ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        dwait   = 100;
        imem[0] = 32'h04002303;      // lw x6,0x40(x0)
        rst = 1'b0;
        wait_for("t6_dbus_req", 2, 20);
        repeat (2) @(posedge clk);
        #1;
        check("t6_still_waiting", {31'd0, dbus_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_dbus_req_drop", {31'd0, dbus_req}, 32'd0);
        check("t6_ibus_req_drop", {31'd0, ibus_req}, 32'd0);
        check("t6_pc_reset",      pc, 32'h0);
        rst = 1'b0;
        dack_force = 1'b1;
        @(posedge clk);
        #1;
        dack_force = 1'b0;
        check("t6_refetch_req",   {31'd0, ibus_req}, 32'd1);
        check("t6_refetch_addr",  ibus_addr, 32'h0);
        check("t6_late_ack_no_retire", {31'd0, retire}, 32'd0);
        nret = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (retire) nret++;
        end
        check("t6_no_retire",     32'(nret), 32'd0);
        check("t6_reissued_req",  {31'd0, dbus_req}, 32'd1);
        check("t6_reissued_addr", dbus_addr, 32'h40);
        check("t6_reissued_size", {30'd0, dbus_size}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
